// File: rtl/vga_sync_if.sv
// Sync pair from the VGA timing generator plus the monitor's regenerated
// timing and violation reporting.
interface vga_sync_if;
  logic        hsync;
  logic        vsync;
  logic        locked;
  logic [15:0] x;
  logic [15:0] y;
  logic        active;
  logic        frame_start;
  logic        err;
  logic [2:0]  err_code;
  logic [7:0]  err_count;

  modport master (
    output hsync, vsync,
    input  locked, x, y, active, frame_start, err, err_code, err_count
  );

  modport slave (
    input  hsync, vsync,
    output locked, x, y, active, frame_start, err, err_code, err_count
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Locks onto an hsync/vsync stream, regenerates pixel coordinates and an
// active-video flag, and flags and counts timing violations.
module vga_sync_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_ACT    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  vga_sync_if.slave vga
);
  localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_TMO    = 16'(2 * (H_ACTIVE + H_FP + H_SYNC + H_BP));
  localparam logic [15:0] H_START  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_END    = 16'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [15:0] V_START  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_END    = 16'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic        ACT      = (SYNC_ACT != 0);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_LINE = 3'd1, E_HSYNC = 3'd2,
    E_FRAME = 3'd3, E_VSYNC = 3'd4, E_TIMEOUT = 3'd5
  } err_t;

  logic        hs_q, hs_d, vs_q, vs_d;
  logic        hs_lead, hs_trail, vs_lead, vs_trail, frame_edge;
  logic [15:0] h_pos_q, h_pos_n, v_pos_q, v_pos_n;
  logic [15:0] vs_lines_q, vs_lines_n;
  logic        vs_pend_q, vs_pend_n;
  state_t      state_q, state_n;
  logic [7:0]  good_q, good_n;
  err_t        viol_code;
  logic        viol_any, fs_n, in_area, show;

  logic        locked_q, active_q, fs_q, err_q;
  logic [15:0] x_q, y_q;
  logic [2:0]  code_q;
  logic [7:0]  count_q;

  // Inputs are already in the clk domain: one register stage plus history
  // for edge detection. Idle level at reset so the first pulse is an edge.
  // NOTE: every clocked process uses <= so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= ~ACT;
      hs_d <= ~ACT;
      vs_q <= ~ACT;
      vs_d <= ~ACT;
    end else begin
      hs_q <= vga.hsync;
      hs_d <= hs_q;
      vs_q <= vga.vsync;
      vs_d <= vs_q;
    end
  end

  assign hs_lead    = (hs_q == ACT) && (hs_d != ACT);
  assign hs_trail   = (hs_q != ACT) && (hs_d == ACT);
  assign vs_lead    = (vs_q == ACT) && (vs_d != ACT);
  assign vs_trail   = (vs_q != ACT) && (vs_d == ACT);
  assign frame_edge = hs_lead && (vs_lead || vs_pend_q);

  // Position of the pixel currently in the input register.
  always_comb begin
    h_pos_n    = h_pos_q;
    v_pos_n    = v_pos_q;
    vs_pend_n  = vs_pend_q;
    vs_lines_n = vs_lines_q;
    if (hs_lead)                h_pos_n = '0;
    else if (h_pos_q != H_TMO)  h_pos_n = h_pos_q + 16'd1;
    if (frame_edge)             v_pos_n = '0;
    else if (hs_lead && v_pos_q != 16'hFFFF) v_pos_n = v_pos_q + 16'd1;
    if (frame_edge)             vs_pend_n = 1'b0;
    else if (vs_lead)           vs_pend_n = 1'b1;
    // vsync width in lines = hsync leading edges seen while vsync asserted
    if (vs_lead)                vs_lines_n = hs_lead ? 16'd1 : 16'd0;
    else if (vs_q == ACT && hs_lead && vs_lines_q != 16'hFFFF)
      vs_lines_n = vs_lines_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos_q    <= '0;
      v_pos_q    <= '0;
      vs_pend_q  <= 1'b0;
      vs_lines_q <= '0;
    end else begin
      h_pos_q    <= h_pos_n;
      v_pos_q    <= v_pos_n;
      vs_pend_q  <= vs_pend_n;
      vs_lines_q <= vs_lines_n;
    end
  end

  // Checks are written highest code first so the lowest simultaneous code wins.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    viol_code = E_NONE;
    if (state_q != SEARCH) begin
      if (h_pos_n == H_TMO && h_pos_q != H_TMO)      viol_code = E_TIMEOUT;
      if (vs_trail && vs_lines_q != V_SYNC_W)        viol_code = E_VSYNC;
      if (frame_edge && v_pos_q + 16'd1 != V_TOTAL)  viol_code = E_FRAME;
      if (hs_trail && h_pos_n != H_SYNC_W)           viol_code = E_HSYNC;
      if (hs_lead && h_pos_q + 16'd1 != H_TOTAL)     viol_code = E_LINE;
    end
  end

  assign viol_any = (viol_code != E_NONE);

  always_comb begin
    state_n = state_q;
    good_n  = good_q;
    fs_n    = 1'b0;
    if (viol_any) begin
      state_n = SEARCH;
      good_n  = '0;
    end else if (frame_edge) begin
      fs_n = 1'b1;
      unique case (state_q)
        SEARCH: begin
          state_n = CHECK;
          good_n  = '0;
        end
        CHECK: begin
          good_n = good_q + 8'd1;
          if (good_q + 8'd1 >= LOCK_N) state_n = LOCKED;
        end
        default: state_n = LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_n;
      good_q  <= good_n;
    end
  end

  assign in_area = (h_pos_n >= H_START) && (h_pos_n <= H_END) &&
                   (v_pos_n >= V_START) && (v_pos_n <= V_END);
  assign show    = (state_n == LOCKED) && in_area;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      count_q  <= '0;
    end else begin
      locked_q <= (state_n == LOCKED);
      active_q <= show;
      x_q      <= show ? h_pos_n - H_START : '0;
      y_q      <= show ? v_pos_n - V_START : '0;
      fs_q     <= fs_n;
      err_q    <= viol_any;
      if (viol_any) begin
        code_q <= viol_code;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
    end
  end

  assign vga.locked      = locked_q;
  assign vga.active      = active_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = fs_q;
  assign vga.err         = err_q;
  assign vga.err_code    = code_q;
  assign vga.err_count   = count_q;
endmodule
